control_sequencer: RTL

- Hardwired control unit directly upstream of DataPath.
- Replaces the hand-sequenced T0..T7 testbench stimulus: drives every DataPath select, enable, ALU and memory strobe.
- Fetches, decodes and executes one instruction at a time, waiting on the ALU `finished` and memory `memFinished` handshakes.
- Outputs are registered and change on the Clock rising edge; DataPath samples them on the following edge.

---
 rtl/cpu_ctrl_pkg.sv | 65 ++++++
 rtl/ctrl_decode.sv | 40 ++++
 rtl/control_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Opcodes, ALU codes, FSM states and output bundle for control_sequencer
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam int unsigned c_OP_LD   = 0;
    localparam int unsigned c_OP_LDI  = 1;
    localparam int unsigned c_OP_ST   = 2;
    localparam int unsigned c_OP_ADD  = 3;
    localparam int unsigned c_OP_SUB  = 4;
    localparam int unsigned c_OP_AND  = 5;
    localparam int unsigned c_OP_OR   = 6;
    localparam int unsigned c_OP_ADDI = 12;
    localparam int unsigned c_OP_ANDI = 13;
    localparam int unsigned c_OP_ORI  = 14;
    localparam int unsigned c_OP_NOP  = 26;
    localparam int unsigned c_OP_HALT = 27;

    localparam logic [5:0] c_ALU_ADD = 6'b000100;
    localparam logic [5:0] c_ALU_SUB = 6'b000101;
    localparam logic [5:0] c_ALU_AND = 6'b001010;
    localparam logic [5:0] c_ALU_OR  = 6'b001011;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_F0    = 4'd1,
        S_F1    = 4'd2,
        S_F2    = 4'd3,
        S_DEC   = 4'd4,
        S_E3    = 4'd5,
        S_E4    = 4'd6,
        S_WAITA = 4'd7,
        S_E5    = 4'd8,
        S_E6    = 4'd9,
        S_E7    = 4'd10,
        S_HALT  = 4'd11,
        S_FAULT = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        CLS_LD   = 3'd0,
        CLS_LDI  = 3'd1,
        CLS_ST   = 3'd2,
        CLS_ALUR = 3'd3,
        CLS_ALUI = 3'd4,
        CLS_NOP  = 3'd5,
        CLS_HALT = 3'd6,
        CLS_ILL  = 3'd7
    } instr_cls_e;

    typedef struct packed {
        logic PCout;  logic IRout;  logic MDRout; logic RZLOout; logic RZHIout;
        logic RHIout; logic RLOout; logic Immout; logic BAout;   logic Rout;
        logic PCin;   logic IRin;   logic MARin;  logic MDRin;   logic RYin;
        logic RZin;   logic RHIin;  logic RLOin;  logic Rin;
        logic Gra;    logic Grb;    logic Grc;
        logic IncPC;  logic Read;   logic Write;  logic start;
        logic halted; logic fault;
    } ctrl_out_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational opcode -> instruction class and ALU operation map
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 6
) (
    input  logic [OPW-1:0]  opcode,
    output instr_cls_e      cls,
    output logic [ALUW-1:0] alu_op
);

    // Memory classes use ADD for base + offset address formation
    always_comb begin
        cls    = CLS_ILL;
        alu_op = ALUW'(c_ALU_ADD);
        case (opcode)
            OPW'(c_OP_LD):   cls = CLS_LD;
            OPW'(c_OP_LDI):  cls = CLS_LDI;
            OPW'(c_OP_ST):   cls = CLS_ST;
            OPW'(c_OP_ADD):  cls = CLS_ALUR;
            OPW'(c_OP_SUB):  begin cls = CLS_ALUR; alu_op = ALUW'(c_ALU_SUB); end
            OPW'(c_OP_AND):  begin cls = CLS_ALUR; alu_op = ALUW'(c_ALU_AND); end
            OPW'(c_OP_OR):   begin cls = CLS_ALUR; alu_op = ALUW'(c_ALU_OR);  end
            OPW'(c_OP_ADDI): cls = CLS_ALUI;
            OPW'(c_OP_ANDI): begin cls = CLS_ALUI; alu_op = ALUW'(c_ALU_AND); end
            OPW'(c_OP_ORI):  begin cls = CLS_ALUI; alu_op = ALUW'(c_ALU_OR);  end
            OPW'(c_OP_NOP):  cls = CLS_NOP;
            OPW'(c_OP_HALT): cls = CLS_HALT;
            default:         cls = CLS_ILL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Brief    : Hardwired fetch/decode/execute sequencer driving the DataPath strobes.
//            Define CTRL_TIMEOUT_EN to add a handshake watchdog (TMO_CYCLES).
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW        = 5,
    parameter int ALUW       = 6,
    parameter int TMO_CYCLES = 64
) (
    input  logic            Clock,
    input  logic            clear,
    input  logic            run,
    input  logic [31:0]     IR,
    input  logic            finished,
    input  logic            memFinished,
    output logic            PCout,
    output logic            IRout,
    output logic            MDRout,
    output logic            RZLOout,
    output logic            RZHIout,
    output logic            RHIout,
    output logic            RLOout,
    output logic            Immout,
    output logic            BAout,
    output logic            Rout,
    output logic            PCin,
    output logic            IRin,
    output logic            MARin,
    output logic            MDRin,
    output logic            RYin,
    output logic            RZin,
    output logic            RHIin,
    output logic            RLOin,
    output logic            Rin,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            IncPC,
    output logic            Read,
    output logic            Write,
    output logic            start,
    output logic [ALUW-1:0] opSelect,
    output logic            halted,
    output logic            fault
);

    state_e          r_state, w_nxt, w_nxt_base, w_done;
    instr_cls_e      r_cls, w_dec_cls, w_cls;
    logic [ALUW-1:0] r_alu, w_dec_alu, r_op, w_op;
    logic            r_fin_early;
    ctrl_out_t       r_out, w_out;
    logic            w_unused_ir;

    ctrl_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
        .opcode (IR[31 -: OPW]),
        .cls    (w_dec_cls),
        .alu_op (w_dec_alu)
    );

    assign w_unused_ir = ^IR[31-OPW:0];
    assign w_done      = run ? S_F0 : S_IDLE;
    // Class is latched in DEC; the DEC->E3 transition must see it early
    assign w_cls       = (r_state == S_DEC) ? w_dec_cls : r_cls;

    always_comb begin
        w_nxt_base = r_state;
        case (r_state)
            S_IDLE:  if (run) w_nxt_base = S_F0;
            S_F0:    w_nxt_base = S_F1;
            S_F1:    if (memFinished) w_nxt_base = S_F2;
            S_F2:    w_nxt_base = S_DEC;
            S_DEC: begin
                case (w_dec_cls)
                    CLS_NOP:  w_nxt_base = w_done;
                    CLS_HALT: w_nxt_base = S_HALT;
                    CLS_ILL:  w_nxt_base = S_FAULT;
                    default:  w_nxt_base = S_E3;
                endcase
            end
            S_E3:    w_nxt_base = S_E4;
            S_E4:    w_nxt_base = S_WAITA;
            S_WAITA: if (finished || r_fin_early) w_nxt_base = S_E5;
            S_E5:    w_nxt_base = (r_cls == CLS_LD || r_cls == CLS_ST) ? S_E6 : w_done;
            S_E6:    if (r_cls != CLS_LD || memFinished) w_nxt_base = S_E7;
            S_E7:    if (r_cls != CLS_ST || memFinished) w_nxt_base = w_done;
            S_HALT, S_FAULT: w_nxt_base = r_state;
            default: w_nxt_base = S_IDLE;
        endcase
    end

`ifdef CTRL_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TMO_CYCLES) + 1;

    logic [c_CNT_W-1:0] r_tmo;
    logic               w_in_wait, w_hs;

    always_comb begin
        w_in_wait = 1'b0;
        w_hs      = 1'b0;
        case (r_state)
            S_F1:    begin w_in_wait = 1'b1; w_hs = memFinished; end
            S_WAITA: begin w_in_wait = 1'b1; w_hs = finished || r_fin_early; end
            S_E6:    begin w_in_wait = (r_cls == CLS_LD); w_hs = memFinished; end
            S_E7:    begin w_in_wait = (r_cls == CLS_ST); w_hs = memFinished; end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear)                 r_tmo <= '0;
        else if (w_nxt != r_state)  r_tmo <= '0;
        else if (w_in_wait)         r_tmo <= r_tmo + c_CNT_W'(1);
    end

    assign w_nxt = (w_in_wait && !w_hs && r_tmo == c_CNT_W'(TMO_CYCLES - 1)) ? S_FAULT : w_nxt_base;
`else
    localparam int c_UNUSED_TMO = TMO_CYCLES;
    assign w_nxt = w_nxt_base;
`endif

    // BAout is the register-file read with R0 forced to zero; it replaces Rout as the base source
    always_comb begin
        w_out = '0;
        w_op  = '0;
        case (w_nxt)
            S_F0:    begin w_out.PCout = 1'b1; w_out.MARin = 1'b1; w_out.IncPC = 1'b1; end
            S_F1:    begin w_out.Read = 1'b1; w_out.MDRin = 1'b1; end
            S_F2:    begin w_out.MDRout = 1'b1; w_out.IRin = 1'b1; end
            S_E3: begin
                w_out.Grb  = 1'b1;
                w_out.RYin = 1'b1;
                if (w_cls == CLS_ALUR || w_cls == CLS_ALUI) w_out.Rout  = 1'b1;
                else                                        w_out.BAout = 1'b1;
            end
            S_E4: begin
                w_out.RZin  = 1'b1;
                w_out.start = 1'b1;
                w_op        = r_alu;
                if (w_cls == CLS_ALUR) begin w_out.Grc = 1'b1; w_out.Rout = 1'b1; end
                else                         w_out.Immout = 1'b1;
            end
            S_WAITA: begin w_out.RZin = 1'b1; w_op = r_alu; end
            S_E5: begin
                w_out.RZLOout = 1'b1;
                if (w_cls == CLS_LD || w_cls == CLS_ST) w_out.MARin = 1'b1;
                else begin w_out.Gra = 1'b1; w_out.Rin = 1'b1; end
            end
            S_E6: begin
                w_out.MDRin = 1'b1;
                if (w_cls == CLS_LD) w_out.Read = 1'b1;
                else begin w_out.Gra = 1'b1; w_out.Rout = 1'b1; end
            end
            S_E7: begin
                if (w_cls == CLS_LD) begin
                    w_out.MDRout = 1'b1; w_out.Gra = 1'b1; w_out.Rin = 1'b1;
                end else begin
                    w_out.Write = 1'b1;
                end
            end
            S_HALT:  w_out.halted = 1'b1;
            S_FAULT: w_out.fault  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_state     <= S_IDLE;
            r_cls       <= CLS_NOP;
            r_alu       <= '0;
            r_fin_early <= 1'b0;
            r_out       <= '0;
            r_op        <= '0;
        end else begin
            r_state     <= w_nxt;
            r_out       <= w_out;
            r_op        <= w_op;
            r_fin_early <= (r_state == S_E4) && finished;
            if (r_state == S_DEC) begin
                r_cls <= w_dec_cls;
                r_alu <= w_dec_alu;
            end
        end
    end

    assign PCout    = r_out.PCout;
    assign IRout    = r_out.IRout;
    assign MDRout   = r_out.MDRout;
    assign RZLOout  = r_out.RZLOout;
    assign RZHIout  = r_out.RZHIout;
    assign RHIout   = r_out.RHIout;
    assign RLOout   = r_out.RLOout;
    assign Immout   = r_out.Immout;
    assign BAout    = r_out.BAout;
    assign Rout     = r_out.Rout;
    assign PCin     = r_out.PCin;
    assign IRin     = r_out.IRin;
    assign MARin    = r_out.MARin;
    assign MDRin    = r_out.MDRin;
    assign RYin     = r_out.RYin;
    assign RZin     = r_out.RZin;
    assign RHIin    = r_out.RHIin;
    assign RLOin    = r_out.RLOin;
    assign Rin      = r_out.Rin;
    assign Gra      = r_out.Gra;
    assign Grb      = r_out.Grb;
    assign Grc      = r_out.Grc;
    assign IncPC    = r_out.IncPC;
    assign Read     = r_out.Read;
    assign Write    = r_out.Write;
    assign start    = r_out.start;
    assign halted   = r_out.halted;
    assign fault    = r_out.fault;
    assign opSelect = r_op;

endmodule
`default_nettype wire
